// File: rtl/event_updown_counter.sv
// Up/down event counter: asynchronous inc/dec lines are synchronised, rising-edge
// detected and applied to a modulus counter with wrap or saturate behaviour.
module event_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MAX         = 2**WIDTH-1,
  parameter bit SATURATE    = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] dec_sync;
  logic                   inc_hist;
  logic                   dec_hist;
  logic                   inc_evt;
  logic                   dec_evt;
  logic [WIDTH:0]         up_sum;
  logic [WIDTH-1:0]       load_clamped;

  // Synchronisers and history flops reset high so a line held high through
  // reset release does not look like a fresh rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_sync <= '1;
      dec_sync <= '1;
      inc_hist <= 1'b1;
      dec_hist <= 1'b1;
    end else begin
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], inc};
      dec_sync <= {dec_sync[SYNC_STAGES-2:0], dec};
      inc_hist <= inc_sync[SYNC_STAGES-1];
      dec_hist <= dec_sync[SYNC_STAGES-1];
    end
  end

  assign inc_evt = en & inc_sync[SYNC_STAGES-1] & ~inc_hist;
  assign dec_evt = en & dec_sync[SYNC_STAGES-1] & ~dec_hist;

  // One extra bit so the step past MAX is visible rather than wrapping silently.
  assign up_sum       = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_VAL : load_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (load) begin
        count <= load_clamped;
      end else if (inc_evt && !dec_evt) begin
        if (up_sum > MAX_EXT) begin
          count <= SATURATE ? MAX_VAL : '0;
          ovf   <= 1'b1;
          tc    <= 1'b1;
        end else begin
          count <= up_sum[WIDTH-1:0];
        end
      end else if (dec_evt && !inc_evt) begin
        if (count == '0) begin
          count <= SATURATE ? '0 : MAX_VAL;
          ovf   <= 1'b1;
          tc    <= 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_event_updown_counter.sv
// Directed bench for event_updown_counter: a default 8-bit wrap instance plus
// WIDTH=4/MAX=9 wrap and saturate instances, each with its own stimulus.
module tb_event_updown_counter;

  logic       clk;
  logic       rst;
  logic [2:0] clr, en, inc, dec, load;
  logic [7:0] lv0;
  logic [3:0] lv1, lv2;
  logic [7:0] count0;
  logic [3:0] count1, count2;
  logic [2:0] zero, tc, ovf;

  int checks   = 0;
  int failures = 0;
  int tc_cnt [3] = '{0, 0, 0};

  event_updown_counter u_dflt (
    .clk(clk), .rst(rst), .clr(clr[0]), .en(en[0]), .inc(inc[0]), .dec(dec[0]),
    .load(load[0]), .load_val(lv0), .count(count0), .zero(zero[0]), .tc(tc[0]), .ovf(ovf[0])
  );

  event_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr[1]), .en(en[1]), .inc(inc[1]), .dec(dec[1]),
    .load(load[1]), .load_val(lv1), .count(count1), .zero(zero[1]), .tc(tc[1]), .ovf(ovf[1])
  );

  event_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr[2]), .en(en[2]), .inc(inc[2]), .dec(dec[2]),
    .load(load[2]), .load_val(lv2), .count(count2), .zero(zero[2]), .tc(tc[2]), .ovf(ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting tc samples at mid-cycle also catches a tc that stays high too long.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) tc_cnt[i] += int'(tc[i]);
  end

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int idx, input bit up);
    if (up) inc[idx] = 1'b1;
    else    dec[idx] = 1'b1;
    tick(4);
    inc[idx] = 1'b0;
    dec[idx] = 1'b0;
    tick(4);
  endtask

  initial begin
    rst  = 1'b0;
    clr  = '0;
    en   = '1;
    inc  = 3'b001;
    dec  = '0;
    load = '0;
    lv0  = '0;
    lv1  = '0;
    lv2  = '0;
    tick(3);

    check("rst_count0", int'(count0), 0);
    check("rst_count1", int'(count1), 0);
    check("rst_count2", int'(count2), 0);
    check("rst_zero",   int'(zero), 7);
    check("rst_tc",     int'(tc), 0);
    check("rst_ovf",    int'(ovf), 0);

    // inc held high through reset release must not count
    rst = 1'b1;
    tick(10);
    check("hold_high_count", int'(count0), 0);
    check("hold_high_tc",    tc_cnt[0], 0);
    inc[0] = 1'b0;
    tick(4);
    inc[0] = 1'b1;
    tick(2);
    check("latency_before", int'(count0), 0);
    tick(1);
    check("latency_third_edge", int'(count0), 1);
    inc[0] = 1'b0;
    tick(4);

    // wrap mode, MAX = 9
    for (int p = 1; p <= 10; p++) begin
      pulse(1, 1'b1);
      check($sformatf("wrap_inc%0d", p), int'(count1), p % 10);
      check($sformatf("wrap_tc%0d", p), tc_cnt[1], (p == 10) ? 1 : 0);
    end
    check("wrap_ovf",  int'(ovf[1]), 1);
    check("wrap_zero", int'(zero[1]), 1);
    pulse(1, 1'b0);
    check("wrap_dec_count", int'(count1), 9);
    check("wrap_dec_tc",    tc_cnt[1], 2);
    check("wrap_dec_ovf",   int'(ovf[1]), 1);

    // saturate mode, MAX = 9
    load[2] = 1'b1;
    lv2     = 4'd15;
    tick(1);
    load[2] = 1'b0;
    check("sat_load_clamp", int'(count2), 9);
    check("sat_load_ovf",   int'(ovf[2]), 0);
    for (int p = 1; p <= 3; p++) begin
      pulse(2, 1'b1);
      check($sformatf("sat_hold%0d", p), int'(count2), 9);
    end
    check("sat_tc_pulses", tc_cnt[2], 3);
    check("sat_ovf",       int'(ovf[2]), 1);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    check("sat_clr_count", int'(count2), 0);
    check("sat_clr_ovf",   int'(ovf[2]), 0);
    check("sat_clr_zero",  int'(zero[2]), 1);
    pulse(2, 1'b0);
    check("sat_dec_hold", int'(count2), 0);
    check("sat_dec_tc",   tc_cnt[2], 4);
    check("sat_dec_ovf",  int'(ovf[2]), 1);

    // simultaneous events and enable
    load[0] = 1'b1;
    lv0     = 8'd5;
    tick(1);
    load[0] = 1'b0;
    check("load5", int'(count0), 5);
    inc[0] = 1'b1;
    dec[0] = 1'b1;
    tick(4);
    inc[0] = 1'b0;
    dec[0] = 1'b0;
    tick(4);
    check("both_count", int'(count0), 5);
    check("both_tc",    tc_cnt[0], 0);
    en[0] = 1'b0;
    for (int p = 0; p < 4; p++) pulse(0, 1'b1);
    check("en_low_count", int'(count0), 5);
    en[0] = 1'b1;
    tick(6);
    check("en_restore_no_queue", int'(count0), 5);
    pulse(0, 1'b1);
    check("en_high_inc", int'(count0), 6);

    // priority: clr over load over recognised event
    inc[0] = 1'b1;
    tick(2);
    clr[0]  = 1'b1;
    load[0] = 1'b1;
    lv0     = 8'd7;
    tick(1);
    clr[0]  = 1'b0;
    load[0] = 1'b0;
    check("prio_clr", int'(count0), 0);
    tick(3);
    check("prio_clr_dropped", int'(count0), 0);
    inc[0] = 1'b0;
    tick(4);
    inc[0] = 1'b1;
    tick(2);
    load[0] = 1'b1;
    tick(1);
    load[0] = 1'b0;
    check("prio_load", int'(count0), 7);
    tick(3);
    check("prio_load_dropped", int'(count0), 7);
    inc[0] = 1'b0;
    tick(4);

    // reset in mid-cycle with count = 200, ovf = 1
    load[0] = 1'b1;
    lv0     = 8'd255;
    tick(1);
    load[0] = 1'b0;
    pulse(0, 1'b1);
    check("wrap255_count", int'(count0), 0);
    load[0] = 1'b1;
    lv0     = 8'd200;
    tick(1);
    load[0] = 1'b0;
    check("pre_rst_count", int'(count0), 200);
    check("pre_rst_ovf",   int'(ovf[0]), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", int'(count0), 0);
    check("async_rst_zero",  int'(zero[0]), 1);
    check("async_rst_tc",    int'(tc[0]), 0);
    check("async_rst_ovf",   int'(ovf[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
